// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rob_pkg
// Brief    : Shared sizes and types for the reorder-buffer controller.
// Revision : 1.0 - initial release
// ============================================================================
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ID_W      = 4;
  localparam int PTR_W     = 5;

  typedef logic [ID_W-1:0]  rob_id_t;
  typedef logic [PTR_W-1:0] rob_ptr_t;

  // Strip the wrap bit from a pointer to get the entry index.
  function automatic rob_id_t ptr_idx(input rob_ptr_t ptr);
    return ptr[ID_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_storage.sv
`default_nettype none
// ============================================================================
// Module   : rob_storage
// Brief    : Payload array for the reorder buffer. One synchronous write
//            port (completion), one asynchronous read port (retire head).
//            Contents are intentionally not reset.
// Revision : 1.0 - initial release
// ============================================================================
module rob_storage
  import rob_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ID_W-1:0]       wr_id_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ID_W-1:0]       rd_id_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] r_mem [ROB_DEPTH];

  // Completion data lands in its slot on the clock edge.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_id_i] <= wr_data_i;
    end
  end

  assign rd_data_o = r_mem[rd_id_i];

endmodule
`default_nettype wire

// File: rtl/rob_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rob_ctrl
// Brief    : 16-entry reorder buffer controller. Tags are allocated in
//            order at the tail, completed out of order by id, and retired
//            in order from the head. Illegal completions raise a one-cycle
//            registered error pulse; flush discards every entry.
// Revision : 1.0 - initial release
// ============================================================================
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  flush_i,
  // in-order allocation
  input  logic                  alloc_req_i,
  output logic                  alloc_gnt_o,
  output logic [ID_W-1:0]       alloc_id_o,
  // out-of-order completion
  input  logic                  cpl_valid_i,
  input  logic [ID_W-1:0]       cpl_id_i,
  input  logic [DATA_WIDTH-1:0] cpl_data_i,
  // in-order retirement
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ID_W-1:0]       out_id_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  // status
  output logic [PTR_W-1:0]      count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  err_o
);

  rob_ptr_t             r_head;
  rob_ptr_t             r_tail;
  logic [ROB_DEPTH-1:0] r_alloc;
  logic [ROB_DEPTH-1:0] r_done;
  logic                 r_err;

  logic [ROB_DEPTH-1:0] w_alloc_nxt;
  logic [ROB_DEPTH-1:0] w_done_nxt;
  rob_id_t              w_head_idx;
  rob_id_t              w_tail_idx;
  rob_ptr_t             w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_grant;
  logic                 w_cpl_legal;
  logic                 w_cpl_illegal;
  logic                 w_out_valid;
  logic                 w_retire;
  logic                 w_wr_en;

  // ---------------------------------------------------------------------------
  // Occupancy and handshake decode (all from registered state plus inputs)
  // ---------------------------------------------------------------------------
  assign w_head_idx = ptr_idx(r_head);
  assign w_tail_idx = ptr_idx(r_tail);

  // The wrap bit makes tail-head unambiguous across 0..16.
  assign w_count = r_tail - r_head;
  assign w_full  = (w_count == rob_ptr_t'(ROB_DEPTH));
  assign w_empty = (w_count == '0);

  // Fullness is judged before any same-cycle retire, so a full buffer never
  // grants even while it drains. Reset also masks the grant.
  assign w_grant = alloc_req_i & ~w_full & ~flush_i & resetn_i;

  // A completion must hit an entry that is allocated and still pending.
  assign w_cpl_legal   = cpl_valid_i & r_alloc[cpl_id_i] & ~r_done[cpl_id_i];
  assign w_cpl_illegal = cpl_valid_i & ~w_cpl_legal & ~flush_i;
  assign w_wr_en       = w_cpl_legal & ~flush_i;

  // Head readiness comes from flags only, giving one cycle of completion
  // latency and a valid that is stable until it retires.
  assign w_out_valid = r_alloc[w_head_idx] & r_done[w_head_idx];
  assign w_retire    = w_out_valid & out_ready_i & ~flush_i;

  // Next-state for the per-entry flags; grant, completion and retire always
  // address distinct entries so their updates never collide.
  always_comb begin
    w_alloc_nxt = r_alloc;
    w_done_nxt  = r_done;
    if (flush_i) begin
      w_alloc_nxt = '0;
      w_done_nxt  = '0;
    end else begin
      if (w_grant) begin
        w_alloc_nxt[w_tail_idx] = 1'b1;
        w_done_nxt[w_tail_idx]  = 1'b0;
      end
      if (w_cpl_legal) begin
        w_done_nxt[cpl_id_i] = 1'b1;
      end
      if (w_retire) begin
        w_alloc_nxt[w_head_idx] = 1'b0;
        w_done_nxt[w_head_idx]  = 1'b0;
      end
    end
  end

  // Flag registers: cleared by reset or flush, otherwise follow next-state.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_alloc <= '0;
      r_done  <= '0;
    end else begin
      r_alloc <= w_alloc_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Head/tail pointers advance on retire/grant; flush rewinds both to zero.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_retire) begin
        r_head <= r_head + rob_ptr_t'(1);
      end
      if (w_grant) begin
        r_tail <= r_tail + rob_ptr_t'(1);
      end
    end
  end

  // Error pulse: one registered cycle per rejected completion.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_cpl_illegal;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload storage
  // ---------------------------------------------------------------------------
  rob_storage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_storage (
    .clk_i     (clk_i),
    .wr_en_i   (w_wr_en),
    .wr_id_i   (cpl_id_i),
    .wr_data_i (cpl_data_i),
    .rd_id_i   (w_head_idx),
    .rd_data_o (out_data_o)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alloc_gnt_o = w_grant;
  assign alloc_id_o  = w_tail_idx;
  assign out_valid_o = w_out_valid;
  assign out_id_o    = w_head_idx;
  assign count_o     = w_count;
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rob_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_ctrl
// Brief    : Self-checking bench for rob_ctrl with a queue-based reference
//            model of the buffer contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob_ctrl;

  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          resetn_i = 1'b0;
  logic          flush_i;
  logic          alloc_req_i;
  logic          alloc_gnt_o;
  logic [3:0]    alloc_id_o;
  logic          cpl_valid_i;
  logic [3:0]    cpl_id_i;
  logic [DW-1:0] cpl_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [3:0]    out_id_o;
  logic [DW-1:0] out_data_o;
  logic [4:0]    count_o;
  logic          full_o;
  logic          empty_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  rob_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .flush_i     (flush_i),
    .alloc_req_i (alloc_req_i),
    .alloc_gnt_o (alloc_gnt_o),
    .alloc_id_o  (alloc_id_o),
    .cpl_valid_i (cpl_valid_i),
    .cpl_id_i    (cpl_id_i),
    .cpl_data_i  (cpl_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_id_o    (out_id_o),
    .out_data_o  (out_data_o),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model: ordered list of live entries ----------
  typedef struct {
    int          id;
    bit          done;
    logic [DW-1:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_tail;
  bit   m_err;

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    bit   gnt, ov, ret;
    int   hit;
    ent_t e;
    gnt = alloc_req_i && (mq.size() < 16) && !flush_i;
    hit = -1;
    if (cpl_valid_i) begin
      foreach (mq[k]) if (mq[k].id == int'(cpl_id_i) && !mq[k].done) hit = k;
    end
    ov  = (mq.size() > 0) && mq[0].done;
    ret = ov && out_ready_i && !flush_i;
    if (flush_i) begin
      model_reset();
    end else begin
      m_err = cpl_valid_i && (hit < 0);
      if (hit >= 0) begin
        e = mq[hit]; e.done = 1'b1; e.data = cpl_data_i; mq[hit] = e;
      end
      if (ret) void'(mq.pop_front());
      if (gnt) begin
        e.id = m_tail; e.done = 1'b0; e.data = '0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % 16;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    flush_i = 0; alloc_req_i = 0; cpl_valid_i = 0; cpl_id_i = 0;
    cpl_data_i = 0; out_ready_i = 0;
  endtask

  task automatic do_flush();
    set_idle();
    flush_i = 1;
    tick();
    flush_i = 0;
  endtask

  task automatic alloc_n(input int n);
    alloc_req_i = 1;
    repeat (n) tick();
    alloc_req_i = 0;
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    set_idle();
    model_reset();
    resetn_i = 0;
    alloc_req_i = 1;
    #12;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%0b required=0", out_valid_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count actual=%0d required=0", count_o); end
    checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin errors++; $display("FAIL reset_flags actual=e%0b/f%0b required=e1/f0", empty_o, full_o); end
    checks++; if (alloc_gnt_o !== 1'b0 || alloc_id_o !== 4'd0) begin errors++; $display("FAIL reset_alloc actual=g%0b/id%0d required=g0/id0", alloc_gnt_o, alloc_id_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err actual=%0b required=0", err_o); end
    alloc_req_i = 0;
    @(negedge clk_i);
    resetn_i = 1;
    tick();
  endtask

  task automatic test_fill();
    alloc_req_i = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      checks++;
      if (alloc_gnt_o !== 1'b1 || alloc_id_o !== 4'(i)) begin
        errors++; $display("FAIL fill_grant actual=g%0b/id%0d required=g1/id%0d", alloc_gnt_o, alloc_id_o, i);
      end
      tick();
    end
    @(negedge clk_i);
    checks++; if (full_o !== 1'b1 || count_o !== 5'd16) begin errors++; $display("FAIL fill_full actual=f%0b/c%0d required=f1/c16", full_o, count_o); end
    checks++; if (alloc_gnt_o !== 1'b0) begin errors++; $display("FAIL fill_17th_grant actual=%0b required=0", alloc_gnt_o); end
    tick();
    alloc_req_i = 0;
  endtask

  task automatic test_out_of_order();
    logic [3:0]    ids [4];
    logic [DW-1:0] dat [4];
    logic [DW-1:0] ret [4];
    ids = '{4'd3, 4'd1, 4'd2, 4'd0};
    dat = '{8'h33, 8'h11, 8'h22, 8'h00};
    ret = '{8'h00, 8'h11, 8'h22, 8'h33};
    do_flush();
    alloc_n(4);
    out_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      cpl_valid_i = 1; cpl_id_i = ids[k]; cpl_data_i = dat[k];
      @(negedge clk_i);
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_early_valid step=%0d actual=%0b required=0", k, out_valid_o); end
      tick();
    end
    cpl_valid_i = 0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk_i);
      checks++;
      if (out_valid_o !== 1'b1 || out_id_o !== 4'(r) || out_data_o !== ret[r]) begin
        errors++; $display("FAIL ooo_retire r=%0d actual=v%0b/id%0d/%02h required=v1/id%0d/%02h", r, out_valid_o, out_id_o, out_data_o, r, ret[r]);
      end
      tick();
    end
    checks++; if (out_valid_o !== 1'b0 || empty_o !== 1'b1) begin errors++; $display("FAIL ooo_drained actual=v%0b/e%0b required=v0/e1", out_valid_o, empty_o); end
    out_ready_i = 0;
  endtask

  task automatic test_illegal();
    do_flush();
    cpl_valid_i = 1; cpl_id_i = 4'd5; cpl_data_i = 8'hFF;
    tick();
    cpl_valid_i = 0;
    @(negedge clk_i);
    checks++; if (err_o !== 1'b1 || count_o !== 5'd0) begin errors++; $display("FAIL ill_unalloc actual=err%0b/c%0d required=err1/c0", err_o, count_o); end
    tick();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ill_pulse_len actual=%0b required=0", err_o); end
    alloc_n(3);
    cpl_valid_i = 1; cpl_id_i = 4'd2; cpl_data_i = 8'h5A;
    tick();
    cpl_data_i = 8'hEE;
    @(negedge clk_i);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ill_legal_err actual=%0b required=0", err_o); end
    tick();
    cpl_valid_i = 0;
    @(negedge clk_i);
    checks++; if (err_o !== 1'b1 || count_o !== 5'd3 || out_valid_o !== 1'b0) begin errors++; $display("FAIL ill_double actual=err%0b/c%0d/v%0b required=err1/c3/v0", err_o, count_o, out_valid_o); end
    tick();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ill_double_len actual=%0b required=0", err_o); end
    cpl_valid_i = 1; cpl_id_i = 4'd0; cpl_data_i = 8'hA0; tick();
    cpl_id_i = 4'd1; cpl_data_i = 8'hA1; tick();
    cpl_valid_i = 0;
    out_ready_i = 1;
    for (int r = 0; r < 3; r++) begin
      logic [DW-1:0] exp_d;
      exp_d = (r == 0) ? 8'hA0 : (r == 1) ? 8'hA1 : 8'h5A;
      @(negedge clk_i);
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== exp_d) begin
        errors++; $display("FAIL ill_data r=%0d actual=v%0b/%02h required=v1/%02h", r, out_valid_o, out_data_o, exp_d);
      end
      tick();
    end
    out_ready_i = 0;
  endtask

  task automatic test_random();
    int   nd[$];
    bit   exp_ov;
    bit   prev15;
    int   wraps;
    do_flush();
    prev15 = 0; wraps = 0;
    for (int c = 0; c < 300; c++) begin
      alloc_req_i = ($urandom_range(0, 3) != 0);
      out_ready_i = (c % 2 == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
      nd.delete();
      foreach (mq[k]) if (!mq[k].done) nd.push_back(k);
      cpl_data_i = DW'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        cpl_valid_i = 1; cpl_id_i = 4'($urandom_range(0, 15));
      end else if (nd.size() > 0 && $urandom_range(0, 2) != 0) begin
        cpl_valid_i = 1; cpl_id_i = 4'(mq[nd[$urandom_range(0, nd.size() - 1)]].id);
      end else begin
        cpl_valid_i = 0;
      end
      @(negedge clk_i);
      exp_ov = (mq.size() > 0) && mq[0].done;
      checks++;
      if (alloc_gnt_o !== (alloc_req_i && mq.size() < 16) || alloc_id_o !== 4'(m_tail)) begin
        errors++; $display("FAIL rnd_alloc cyc=%0d actual=g%0b/id%0d required=g%0b/id%0d", c, alloc_gnt_o, alloc_id_o, alloc_req_i && mq.size() < 16, m_tail);
      end
      checks++;
      if (count_o !== 5'(mq.size()) || full_o !== (mq.size() == 16) || empty_o !== (mq.size() == 0) || count_o > 5'd16) begin
        errors++; $display("FAIL rnd_count cyc=%0d actual=c%0d/f%0b/e%0b required=c%0d", c, count_o, full_o, empty_o, mq.size());
      end
      checks++;
      if (out_valid_o !== exp_ov || (exp_ov && (out_id_o !== 4'(mq[0].id) || out_data_o !== mq[0].data))) begin
        errors++; $display("FAIL rnd_out cyc=%0d actual=v%0b/id%0d/%02h required=v%0b", c, out_valid_o, out_id_o, out_data_o, exp_ov);
      end
      checks++;
      if (err_o !== m_err) begin
        errors++; $display("FAIL rnd_err cyc=%0d actual=%0b required=%0b", c, err_o, m_err);
      end
      if (alloc_gnt_o === 1'b1) begin
        if (prev15 && alloc_id_o === 4'd0) wraps++;
        prev15 = (alloc_id_o === 4'd15);
      end
      tick();
    end
    checks++;
    if (wraps < 1) begin errors++; $display("FAIL rnd_wrap actual=%0d required>=1", wraps); end
    set_idle();
  endtask

  task automatic test_full_bypass();
    do_flush();
    alloc_n(16);
    cpl_valid_i = 1; cpl_id_i = 4'd0; cpl_data_i = 8'h77;
    tick();
    cpl_valid_i = 0;
    alloc_req_i = 1; out_ready_i = 1;
    @(negedge clk_i);
    checks++;
    if (alloc_gnt_o !== 1'b0 || full_o !== 1'b1 || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL bypass_same_cycle actual=g%0b/f%0b/v%0b required=g0/f1/v1", alloc_gnt_o, full_o, out_valid_o);
    end
    tick();
    out_ready_i = 0;
    @(negedge clk_i);
    checks++;
    if (count_o !== 5'd15 || alloc_gnt_o !== 1'b1 || alloc_id_o !== 4'd0) begin
      errors++; $display("FAIL bypass_next actual=c%0d/g%0b/id%0d required=c15/g1/id0", count_o, alloc_gnt_o, alloc_id_o);
    end
    tick();
    alloc_req_i = 0;
    checks++; if (count_o !== 5'd16 || full_o !== 1'b1) begin errors++; $display("FAIL bypass_refill actual=c%0d/f%0b required=c16/f1", count_o, full_o); end
  endtask

  task automatic test_flush();
    do_flush();
    alloc_n(6);
    for (int k = 0; k < 3; k++) begin
      cpl_valid_i = 1; cpl_id_i = 4'(k); cpl_data_i = 8'(8'h40 + k);
      tick();
    end
    flush_i = 1; cpl_valid_i = 1; cpl_id_i = 4'd4; alloc_req_i = 1; out_ready_i = 1;
    @(negedge clk_i);
    checks++; if (alloc_gnt_o !== 1'b0) begin errors++; $display("FAIL flush_grant actual=%0b required=0", alloc_gnt_o); end
    tick();
    set_idle();
    @(negedge clk_i);
    checks++;
    if (count_o !== 5'd0 || empty_o !== 1'b1 || out_valid_o !== 1'b0 || err_o !== 1'b0 || alloc_id_o !== 4'd0) begin
      errors++; $display("FAIL flush_state actual=c%0d/e%0b/v%0b/err%0b/id%0d required=c0/e1/v0/err0/id0", count_o, empty_o, out_valid_o, err_o, alloc_id_o);
    end
    flush_i = 1; cpl_valid_i = 1; cpl_id_i = 4'd9;
    tick();
    set_idle();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL flush_illegal_err actual=%0b required=0", err_o); end
  endtask

  task automatic test_async_reset();
    do_flush();
    alloc_n(8);
    cpl_valid_i = 1; cpl_id_i = 4'd0; cpl_data_i = 8'h99;
    tick();
    cpl_valid_i = 0;
    out_ready_i = 1;
    @(negedge clk_i);
    checks++; if (out_valid_o !== 1'b1 || count_o !== 5'd8) begin errors++; $display("FAIL arst_pre actual=v%0b/c%0d required=v1/c8", out_valid_o, count_o); end
    #2;
    resetn_i = 0;
    alloc_req_i = 1;
    #1;
    model_reset();
    checks++;
    if (out_valid_o !== 1'b0 || count_o !== 5'd0 || empty_o !== 1'b1 || alloc_gnt_o !== 1'b0) begin
      errors++; $display("FAIL arst_immediate actual=v%0b/c%0d/e%0b/g%0b required=v0/c0/e1/g0", out_valid_o, count_o, empty_o, alloc_gnt_o);
    end
    @(posedge clk_i); #1;
    checks++; if (count_o !== 5'd0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL arst_held actual=c%0d/v%0b required=c0/v0", count_o, out_valid_o); end
    @(negedge clk_i);
    resetn_i = 1;
    out_ready_i = 0;
    #1;
    checks++; if (alloc_gnt_o !== 1'b1) begin errors++; $display("FAIL arst_first_grant actual=%0b required=1", alloc_gnt_o); end
    tick();
    alloc_req_i = 0;
    checks++; if (count_o !== 5'd1 || alloc_id_o !== 4'd1) begin errors++; $display("FAIL arst_after actual=c%0d/id%0d required=c1/id1", count_o, alloc_id_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_out_of_order();
    test_illegal();
    test_random();
    test_full_bypass();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
